// File: rtl/rr_mux_sel_arbiter.sv
// Round-robin arbiter driving the select of an 8:1 mux tree.
// Registered one-hot grant, select and tenure counter; each tenure is capped at MAX_HOLD.
module rr_mux_sel_arbiter #(
  parameter int unsigned N        = 8,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N-1:0]     req_i,
  output logic [N-1:0]     gnt_o,
  output logic [SEL_W-1:0] sel_o,
  output logic             gnt_valid_o,
  output logic [CNT_W-1:0] hold_cnt_o
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  logic [SEL_W-1:0] base;
  logic [SEL_W-1:0] next_ptr;
  logic [SEL_W-1:0] idx;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;
  logic             owner_req;
  logic             others;
  logic             at_limit;

  assign next_ptr  = sel_q + SEL_W'(1);
  assign base      = (state_q == StIdle) ? ptr_q : next_ptr;
  assign owner_req = req_i[sel_q];
  assign others    = |(req_i & ~gnt_q);
  assign at_limit  = (hold_q == CNT_W'(MAX_HOLD));

  // First requester at or after base, wrapping modulo N (N is a power of two).
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    idx        = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = base + SEL_W'(k);
      if (!pick_found && req_i[idx]) begin
        pick_idx   = idx;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d = StGrant;
          sel_d   = pick_idx;
          gnt_d   = N'(1) << pick_idx;
          hold_d  = CNT_W'(1);
        end
      end
      StGrant: begin
        if (!owner_req) begin
          ptr_d = next_ptr;
          if (others) begin
            sel_d  = pick_idx;
            gnt_d  = N'(1) << pick_idx;
            hold_d = CNT_W'(1);
          end else begin
            state_d = StIdle;
            gnt_d   = '0;
            hold_d  = '0;
          end
        end else if (at_limit && others) begin
          // Forced rotation: the search from owner+1 never lands on the owner here.
          ptr_d  = next_ptr;
          sel_d  = pick_idx;
          gnt_d  = N'(1) << pick_idx;
          hold_d = CNT_W'(1);
        end else if (!at_limit) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign sel_o       = sel_q;
  assign gnt_valid_o = (state_q == StGrant);
  assign hold_cnt_o  = hold_q;

endmodule

// File: tb/tb_rr_mux_sel_arbiter.sv
// Bench for rr_mux_sel_arbiter: vector table, directed corner cases and a random run
// checked against an integer-level round-robin reference model.
module tb_rr_mux_sel_arbiter;

  localparam int N       = 8;
  localparam int MaxHold = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       gnt_valid;
  logic [2:0] hold_cnt;

  int checks   = 0;
  int failures = 0;

  rr_mux_sel_arbiter dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .gnt_o       (gnt),
    .sel_o       (sel),
    .gnt_valid_o (gnt_valid),
    .hold_cnt_o  (hold_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit m_busy;
  int m_owner, m_cnt, m_ptr, m_sel;

  typedef struct {
    logic [7:0] req;
    logic [7:0] gnt;
    int         sel;
    bit         valid;
    int         hold;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (!$onehot0(gnt) || (gnt_valid !== (|gnt)) || (gnt_valid && gnt[sel] !== 1'b1)) begin
        failures++;
        $display("FAIL invariant: gnt=%0h sel=%0d valid=%0b", gnt, sel, gnt_valid);
      end
    end
  end

  function automatic int rr_search(input int base, input logic [7:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(base + k) % N]) return (base + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_sel = 0;
  endtask

  task automatic model_step(input logic [7:0] r);
    bit others;
    if (!m_busy) begin
      if (r != 0) begin
        m_owner = rr_search(m_ptr, r);
        m_sel   = m_owner;
        m_busy  = 1;
        m_cnt   = 1;
      end
    end else begin
      others = (r & ~(8'(1) << m_owner)) != 0;
      if (!r[m_owner]) begin
        m_ptr = (m_owner + 1) % N;
        if (others) begin
          m_owner = rr_search(m_ptr, r);
          m_sel   = m_owner;
          m_cnt   = 1;
        end else begin
          m_busy = 0;
          m_cnt  = 0;
        end
      end else if (m_cnt == MaxHold && others) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = rr_search(m_ptr, r);
        m_sel   = m_owner;
        m_cnt   = 1;
      end else if (m_cnt < MaxHold) begin
        m_cnt++;
      end
    end
  endtask

  task automatic cycle(input logic [7:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".gnt"}, gnt, m_busy ? (32'd1 << m_owner) : 32'd0);
    chk({tag, ".sel"}, sel, m_sel);
    chk({tag, ".valid"}, gnt_valid, m_busy);
    chk({tag, ".hold"}, hold_cnt, m_cnt);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] r;

    tbl[0]  = '{8'h08, 8'h08, 3, 1'b1, 1};
    tbl[1]  = '{8'h08, 8'h08, 3, 1'b1, 2};
    tbl[2]  = '{8'h08, 8'h08, 3, 1'b1, 3};
    tbl[3]  = '{8'h08, 8'h08, 3, 1'b1, 4};
    tbl[4]  = '{8'h08, 8'h08, 3, 1'b1, 4};
    tbl[5]  = '{8'h00, 8'h00, 3, 1'b0, 0};
    tbl[6]  = '{8'h05, 8'h01, 0, 1'b1, 1};
    tbl[7]  = '{8'h05, 8'h01, 0, 1'b1, 2};
    tbl[8]  = '{8'h04, 8'h04, 2, 1'b1, 1};
    tbl[9]  = '{8'h04, 8'h04, 2, 1'b1, 2};
    tbl[10] = '{8'h84, 8'h04, 2, 1'b1, 3};
    tbl[11] = '{8'h84, 8'h04, 2, 1'b1, 4};
    tbl[12] = '{8'h84, 8'h80, 7, 1'b1, 1};
    tbl[13] = '{8'h81, 8'h80, 7, 1'b1, 2};
    tbl[14] = '{8'h01, 8'h01, 0, 1'b1, 1};
    tbl[15] = '{8'h00, 8'h00, 0, 1'b0, 0};

    rst_n = 1'b0;
    req   = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst.gnt", gnt, 0);
    chk("rst.sel", sel, 0);
    chk("rst.valid", gnt_valid, 0);
    chk("rst.hold", hold_cnt, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].req);
      chk($sformatf("tbl%0d.gnt", i), gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d.sel", i), sel, tbl[i].sel);
      chk($sformatf("tbl%0d.valid", i), gnt_valid, tbl[i].valid);
      chk($sformatf("tbl%0d.hold", i), hold_cnt, tbl[i].hold);
    end

    // Full contention: each owner keeps the grant exactly MaxHold cycles, no bubbles.
    do_reset();
    for (int i = 0; i < 36; i++) begin
      cycle(8'hFF);
      chk("full.sel", sel, (i / MaxHold) % N);
      chk("full.hold", hold_cnt, (i % MaxHold) + 1);
      chk("full.valid", gnt_valid, 1);
    end

    // Asynchronous reset mid-tenure while requester 4 owns the mux.
    do_reset();
    for (int i = 0; i < 17; i++) cycle(8'hFF);
    chk("midrst.pre_gnt", gnt, 8'h10);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.gnt", gnt, 0);
    chk("midrst.sel", sel, 0);
    chk("midrst.valid", gnt_valid, 0);
    chk("midrst.hold", hold_cnt, 0);
    req = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(8'h00);
      compare_model("postrst");
    end
    cycle(8'hFF);
    chk("postrst.restart_gnt", gnt, 8'h01);

    // Owner 1 drops on the same edge requester 0 rises.
    do_reset();
    cycle(8'h02);
    cycle(8'h02);
    chk("simul.pre_gnt", gnt, 8'h02);
    cycle(8'h01);
    chk("simul.gnt", gnt, 8'h01);
    chk("simul.sel", sel, 0);
    chk("simul.hold", hold_cnt, 1);

    // Random persistent-level traffic against the reference model.
    do_reset();
    r = 8'($urandom);
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(5) == 0) r[b] = ~r[b];
      end
      if ($urandom_range(63) == 0) r = '0;
      cycle(r);
      compare_model("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_mux_sel_arbiter.md
Name: rr_mux_sel_arbiter

Overview:
- Round-robin arbiter that shares one 8:1 mux output among 8 requesters.
- Drives the mux select (sel) and one-hot grant vector from registered state.
- Bounds the tenure of each owner with a hold limit, and rotates priority so every requester is served fairly.
- Sits directly in front of the mux_8x1 tree: sel connects to its sel[2:0] input.

Parameters:
- N, 8, number of requesters (power of two, >= 2).
- SEL_W, 3, select width, equal to log2(N).
- MAX_HOLD, 4, maximum consecutive grant cycles per tenure while other requesters are pending (>= 1).
- CNT_W, 3, hold counter width; must be able to hold MAX_HOLD.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- req, input, N, request per requester; level-sensitive, held high while the requester wants the mux.
- gnt, output, N, one-hot grant, registered; all-zero when no owner.
- sel, output, SEL_W, registered mux select equal to the index of the granted requester; holds its last value when idle.
- gnt_valid, output, 1, registered; high when gnt is non-zero.
- hold_cnt, output, CNT_W, registered count of cycles the current owner has held the grant (1..MAX_HOLD).

Behaviour:
- Reset is asynchronous on rst_n low. While in reset and after release:
  - gnt=0, sel=0, gnt_valid=0, hold_cnt=0.
  - state=IDLE, priority pointer ptr=0.
- All outputs are registered. No combinational path from req to any output.

State machine (2 states):
- IDLE:
  - If req != 0 at an edge: grant the first set bit searching ptr, ptr+1, ..., ptr+N-1 (mod N).
  - On that edge: gnt and sel update, gnt_valid=1, hold_cnt=1, go to GRANT.
  - Latency: req seen at edge k gives gnt visible after edge k.
  - If req == 0: stay in IDLE; outputs keep gnt=0, gnt_valid=0, sel unchanged.
- GRANT, owner o = sel. Each edge evaluates, in priority order:
  1. req[o]=0 (owner released):
     - ptr <= o+1 mod N.
     - If other requests are pending: grant the next requester by RR search from o+1, with no idle bubble; hold_cnt=1.
     - Otherwise go to IDLE, gnt=0, gnt_valid=0, hold_cnt=0.
  2. req[o]=1, hold_cnt==MAX_HOLD, and any other req bit set (forced rotation):
     - Grant the next requester by RR search from o+1; ptr <= o+1; hold_cnt=1.
     - Owner o loses the grant even though req[o] is still high.
  3. req[o]=1, hold_cnt==MAX_HOLD, no other request: keep the grant and hold hold_cnt at MAX_HOLD (saturate, no wrap).
  4. Otherwise: keep the grant, hold_cnt <= hold_cnt+1.
- Pointer rules:
  - ptr changes only when a tenure ends.
  - ptr arithmetic is modulo N (7+1 wraps to 0).
  - ptr is internal; not exposed.
- Simultaneous events:
  - Owner drops req on the same edge a new req rises: the new requester competes in the RR search that edge.
  - A requester that drops req before it is granted is never granted (no latching of requests).
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_valid == |gnt.
  - gnt[sel]==1 whenever gnt_valid=1.
  - The granted bit always had req=1 at the granting edge.
- Reset mid-tenure: outputs clear immediately (asynchronously); ptr returns to 0. After release, arbitration restarts from requester 0.
- Fairness bound: a continuously requesting requester is granted within (N-1)*MAX_HOLD+1 cycles.

Test Plan:
- Reset/idle: assert rst_n=0 mid-simulation with gnt=8'h10 -> gnt=0, sel=0, gnt_valid=0, hold_cnt=0 immediately (before the next clk edge); after release with req=0, outputs stay 0.
- Single requester: req=8'h08 for 10 cycles -> gnt=8'h08 and sel=3 one cycle later; hold_cnt counts 1,2,3,4 then stays 4; drop req -> IDLE next edge, gnt=0.
- Full contention: req=8'hFF held -> owners 0,1,...,7,0 in sequence, each exactly MAX_HOLD=4 cycles; sel steps 0..7 then wraps to 0; no idle cycle between owners.
- Early release: req=8'h05, owner 0 drops req after 2 cycles -> owner 2 granted on the next edge with hold_cnt=1; gnt_valid never drops.
- Pointer wrap: after owner 7 ends its tenure with req=8'h81 -> next grant is requester 0, not requester 7.
- Simultaneous edge: owner 1 drops req the same cycle req[0] rises (req=8'h01) -> requester 0 is granted next edge with sel=0; gnt is never multi-hot (checked by assertion throughout).
